// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle CPU: FSM states, opcodes and datapath mux codes.
// The operand-B mux and the main control FSM both import these constants.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    R_EX    = 4'd7,
    ALU_WB  = 4'd8,
    I_EX    = 4'd9,
    BR_EX   = 4'd10,
    JMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] SRCB_REG    = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_BRANCH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM   = 3'b100;
  localparam logic [2:0] SRCB_LUI    = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_LUI, OP_J: op_supported = 1'b1;
      default:                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the CPU datapath (slave).
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       bad_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, bad_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, bad_op
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle main control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable from the current state.
module mc_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mc_control_fsm_if.master  bus
);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] op_q;

  // The opcode is captured in DECODE; everything after DECODE works from op_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) op_q <= bus.opcode;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   state_nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:            state_nxt = MEM_ADR;
          OP_RTYPE:                state_nxt = R_EX;
          OP_BEQ, OP_BNE:          state_nxt = BR_EX;
          OP_ADDI, OP_ORI, OP_LUI: state_nxt = I_EX;
          OP_J:                    state_nxt = JMP;
          default:                 state_nxt = FETCH;
        endcase
      end
      MEM_ADR: state_nxt = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  state_nxt = bus.mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:  state_nxt = FETCH;
      MEM_WR:  state_nxt = bus.mem_ready ? FETCH : MEM_WR;
      R_EX:    state_nxt = ALU_WB;
      ALU_WB:  state_nxt = FETCH;
      I_EX:    state_nxt = ALU_WB;
      BR_EX:   state_nxt = FETCH;
      JMP:     state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALUOP_ADD;
    bus.pc_source  = PCSRC_ALU;
    bus.bad_op     = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        bus.alu_src_b = SRCB_BRANCH;
        bus.bad_op    = ~op_supported(bus.opcode);
      end
      MEM_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      R_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
      end
      ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (op_q == OP_RTYPE);
      end
      I_EX: begin
        bus.alu_src_a = 1'b1;
        case (op_q)
          OP_ORI: begin
            bus.alu_src_b = SRCB_ZIMM;
            bus.alu_op    = ALUOP_OR;
          end
          OP_LUI:  bus.alu_src_b = SRCB_LUI;
          default: bus.alu_src_b = SRCB_IMM;
        endcase
      end
      BR_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_SUB;
        bus.pc_source = PCSRC_ALUOUT;
        bus.pc_write  = ((op_q == OP_BEQ) & bus.zero) | ((op_q == OP_BNE) & ~bus.zero);
      end
      JMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule
